// File: rtl/mult_share_pkg.sv
// Shared types and widths for the round-robin multiplier-sharing block.
package mult_share_pkg;

    localparam int OP_W   = 16;
    localparam int PROD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RES  = 2'd2
    } state_e;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Request and result channels between the datapath clients (master) and the
// shared multiplier arbiter (slave).
interface mult_share_arbiter_if
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [OP_W*NUM_REQ-1:0] req_a;
    logic [OP_W*NUM_REQ-1:0] req_b;
    logic                    res_valid;
    logic                    res_ready;
    logic [PROD_W-1:0]       res_p;
    logic [ID_W-1:0]         res_id;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_p, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_p, res_id
    );
endinterface

// File: rtl/mult_share_arbiter_mult.sv
// Combinational 16x16 unsigned array multiplier: one shifted partial-product
// row per bit of b, accumulated down an adder chain.
module array_multiplier_16bit
    import mult_share_pkg::*;
(
    input  logic [OP_W-1:0]   a_i,
    input  logic [OP_W-1:0]   b_i,
    output logic [PROD_W-1:0] p_o
);
    logic [PROD_W-1:0] row [OP_W+1];

    assign row[0] = '0;

    for (genvar i = 0; i < OP_W; i++) begin : g_row
        assign row[i+1] = row[i] + (b_i[i] ? (PROD_W'(a_i) << i) : '0);
    end

    assign p_o = row[OP_W];
endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one array multiplier among NUM_REQ requesters;
// returns the registered product tagged with the owning requester id.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    mult_share_arbiter_if.slave bus,
    output logic                busy
);
    state_e            state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   id_q;
    logic [OP_W-1:0]   a_q;
    logic [OP_W-1:0]   b_q;
    logic              res_valid_q;
    logic [PROD_W-1:0] res_p_q;
    logic [ID_W-1:0]   res_id_q;

    logic              gnt_vld;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   cand;
    logic [NUM_REQ-1:0] req_ready;
    logic              accept;
    logic [PROD_W-1:0] prod;

    // First valid requester at or after rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!gnt_vld && bus.req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && state_q == IDLE && gnt_vld) begin
            req_ready = NUM_REQ'(1) << gnt_idx;
        end
    end

    assign accept = |(bus.req_valid & req_ready);

    array_multiplier_16bit u_mul (
        .a_i (a_q),
        .b_i (b_q),
        .p_o (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_valid_q <= 1'b0;
            res_p_q     <= '0;
            res_id_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q      <= bus.req_a[OP_W*gnt_idx +: OP_W];
                        b_q      <= bus.req_b[OP_W*gnt_idx +: OP_W];
                        id_q     <= gnt_idx;
                        rr_ptr_q <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
                        state_q  <= MUL;
                    end
                end
                MUL: begin
                    res_p_q     <= prod;
                    res_id_q    <= id_q;
                    res_valid_q <= 1'b1;
                    state_q     <= RES;
                end
                RES: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.res_valid = res_valid_q;
    assign bus.res_p     = res_p_q;
    assign bus.res_id    = res_id_q;
    assign busy          = !rst && (state_q != IDLE);
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed vector table plus multi-cycle corner sequences and a randomized
// run against a cycle model of the shared multiplier arbiter.
module tb_mult_share_arbiter;
    import mult_share_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    mult_share_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    mult_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int unsigned rid;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] onehot(input int unsigned i);
        return 32'(1) << i;
    endfunction

    task automatic set_ops(input int unsigned r, input logic [15:0] a, input logic [15:0] b);
        bus.req_a[16*r +: 16] = a;
        bus.req_b[16*r +: 16] = b;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          mstate;
        int unsigned mrr;
        logic [3:0]  pend;
        logic [15:0] pa [4];
        logic [15:0] pb [4];
        int unsigned eid;
        logic [31:0] ep;
        int          done;
        int          cyc;

        vecs[0] = '{2, 16'd3,      16'd5,      32'd15};
        vecs[1] = '{0, 16'd0,      16'h1234,   32'd0};
        vecs[2] = '{1, 16'hFFFF,   16'hFFFF,   32'hFFFE0001};
        vecs[3] = '{3, 16'hFFFF,   16'd1,      32'h0000FFFF};
        vecs[4] = '{0, 16'h0100,   16'h0100,   32'h00010000};
        vecs[5] = '{3, 16'd12345,  16'd54321,  32'd670592745};
        vecs[6] = '{1, 16'h8000,   16'd2,      32'h00010000};
        vecs[7] = '{2, 16'hABCD,   16'd0,      32'd0};

        // Reset with every requester asserting.
        rst           = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst ready", 32'(bus.req_ready), 32'd0);
            chk("rst res_valid", 32'(bus.res_valid), 32'd0);
            chk("rst busy", 32'(busy), 32'd0);
        end
        chk("rst res_p", bus.res_p, 32'd0);
        chk("rst res_id", 32'(bus.res_id), 32'd0);
        rst           = 1'b0;
        bus.req_valid = '0;
        tick();

        // Directed vectors: lone requester, accept/MUL/RES timing.
        for (int i = 0; i < 8; i++) begin
            bus.req_valid = 4'(onehot(vecs[i].rid));
            set_ops(vecs[i].rid, vecs[i].a, vecs[i].b);
            bus.res_ready = 1'b1;
            #1;
            chk("vec grant", 32'(bus.req_ready), onehot(vecs[i].rid));
            chk("vec idle busy", 32'(busy), 32'd0);
            tick();
            chk("vec mul ready", 32'(bus.req_ready), 32'd0);
            chk("vec mul busy", 32'(busy), 32'd1);
            chk("vec mul res_valid", 32'(bus.res_valid), 32'd0);
            tick();
            chk("vec res_valid", 32'(bus.res_valid), 32'd1);
            chk("vec res_p", bus.res_p, vecs[i].p);
            chk("vec res_id", 32'(bus.res_id), 32'(vecs[i].rid));
            chk("vec res ready", 32'(bus.req_ready), 32'd0);
            tick();
            chk("vec back idle", 32'(busy), 32'd0);
            chk("vec popped", 32'(bus.res_valid), 32'd0);
            chk("vec regrant", 32'(bus.req_ready), onehot(vecs[i].rid));
            bus.req_valid = '0;
            tick();
            chk("vec drop ignored", 32'(busy), 32'd0);
        end

        // Round-robin from a fresh pointer, including the 3 -> 0 wrap.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int unsigned r = 0; r < 4; r++) set_ops(r, 16'(100 + r), 16'(7 * r + 3));
        bus.req_valid = 4'hF;
        bus.res_ready = 1'b1;
        for (int unsigned op = 0; op < 5; op++) begin
            #1;
            chk("rr grant", 32'(bus.req_ready), onehot(op % 4));
            tick();
            chk("rr mul ready", 32'(bus.req_ready), 32'd0);
            tick();
            chk("rr res_id", 32'(bus.res_id), op % 4);
            chk("rr res_p", bus.res_p, (100 + op % 4) * (7 * (op % 4) + 3));
            tick();
        end

        // Backpressure: pointer now at 1.
        bus.req_valid = 4'b0010;
        bus.res_ready = 1'b0;
        set_ops(1, 16'hFFFF, 16'hFFFF);
        #1;
        chk("bp grant", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = 4'hF;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp res_valid", 32'(bus.res_valid), 32'd1);
            chk("bp res_p", bus.res_p, 32'hFFFE0001);
            chk("bp res_id", 32'(bus.res_id), 32'd1);
            chk("bp ready", 32'(bus.req_ready), 32'd0);
            chk("bp busy", 32'(busy), 32'd1);
            tick();
        end
        bus.res_ready = 1'b1;
        tick();
        chk("bp popped", 32'(bus.res_valid), 32'd0);
        chk("bp idle", 32'(busy), 32'd0);
        chk("bp next grant", 32'(bus.req_ready), 32'h4);
        bus.req_valid = '0;
        tick();

        // Reset while in MUL: pointer at 2, so req 3 alone is granted.
        bus.req_valid = 4'b1000;
        #1;
        chk("mid grant", 32'(bus.req_ready), 32'h8);
        tick();
        chk("mid in mul", 32'(busy), 32'd1);
        bus.req_valid = 4'hF;
        rst = 1'b1;
        #1;
        chk("mid rst ready", 32'(bus.req_ready), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        bus.req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            chk("mid no result", 32'(bus.res_valid), 32'd0);
            chk("mid idle", 32'(busy), 32'd0);
            tick();
        end
        bus.req_valid = 4'b1000;
        #2;
        bus.req_valid = '0;
        tick();
        chk("glitch ignored", 32'(busy), 32'd0);
        bus.req_valid = 4'hF;
        #1;
        chk("mid ptr cleared", 32'(bus.req_ready), 32'h1);
        bus.req_valid = '0;
        tick();

        // Randomized run against a cycle model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mstate = 0;
        mrr    = 0;
        pend   = '0;
        eid    = 0;
        ep     = '0;
        done   = 0;
        cyc    = 0;
        for (int r = 0; r < 4; r++) begin
            pa[r] = '0;
            pb[r] = '0;
        end
        while (done < 1000 && cyc < 20000) begin
            logic [3:0]  er;
            logic        gv;
            int unsigned g;
            #1;
            for (int r = 0; r < 4; r++) begin
                if (!pend[r] && $urandom_range(0, 2) == 0) begin
                    pend[r] = 1'b1;
                    pa[r] = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
                    pb[r] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                end
            end
            bus.req_valid = pend;
            bus.req_a     = {pa[3], pa[2], pa[1], pa[0]};
            bus.req_b     = {pb[3], pb[2], pb[1], pb[0]};
            bus.res_ready = 1'($urandom_range(0, 1));
            #1;
            er = '0;
            gv = 1'b0;
            g  = 0;
            if (mstate == 0) begin
                for (int unsigned k = 0; k < 4; k++) begin
                    if (!gv && pend[(mrr + k) % 4]) begin
                        gv = 1'b1;
                        g  = (mrr + k) % 4;
                    end
                end
            end
            if (gv) er[g] = 1'b1;
            chk("rnd ready", 32'(bus.req_ready), 32'(er));
            chk("rnd res_valid", 32'(bus.res_valid), (mstate == 2) ? 32'd1 : 32'd0);
            if (mstate == 2) begin
                chk("rnd res_p", bus.res_p, ep);
                chk("rnd res_id", 32'(bus.res_id), eid);
            end
            case (mstate)
                0: if (gv) begin
                    ep      = {16'h0, pa[g]} * {16'h0, pb[g]};
                    eid     = g;
                    pend[g] = 1'b0;
                    mrr     = (g + 1) % 4;
                    mstate  = 1;
                end
                1: mstate = 2;
                default: if (bus.res_ready) begin
                    mstate = 0;
                    done++;
                end
            endcase
            @(posedge clk);
            cyc++;
        end
        chk("rnd completed ops", 32'(done), 32'd1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
